// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan display.
// Holds the FSM state encoding, the fixed segment patterns and the glyph
// table. Segment bit order is {g,f,e,d,c,b,a}, all active-low.
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;

  // Glyph lookup for one BCD nibble; non-BCD codes render as a dash.
  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] g;
    g = SEG_DASH;
    case (nib)
      4'd0: g = GLYPH_0;
      4'd1: g = GLYPH_1;
      4'd2: g = GLYPH_2;
      4'd3: g = GLYPH_3;
      4'd4: g = GLYPH_4;
      4'd5: g = GLYPH_5;
      4'd6: g = GLYPH_6;
      4'd7: g = GLYPH_7;
      4'd8: g = GLYPH_8;
      4'd9: g = GLYPH_9;
      default: g = SEG_DASH;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seven_seg_scan_if.sv
// Value-update bus of the scan display.
//   value   : four BCD nibbles, [15:12] = digit 3, [3:0] = digit 0
//   load    : one-cycle strobe from the producer
//   pending : display-side flag, shadow holds a value not yet on the display
// Handshake: load has no ready; every cycle with load=1 is accepted and the
// value captured, the last load before a frame boundary wins. pending rises
// the cycle after a load and falls when the shadow is committed at the
// next frame boundary (digit change to 0) with no load in that cycle.
interface seven_seg_scan_if;
  import seg7_pkg::*;

  logic [15:0] value;
  logic        load;
  logic        pending;

  modport master (output value, output load, input pending);
  modport slave  (input value, input load, output pending);
endinterface

// File: rtl/seg7_decode.sv
// Combinational nibble-to-segment decoder.
//   nibble : BCD digit (A..F shown as a dash)
//   blank  : 1 forces all segments off
//   seg    : {g,f,e,d,c,b,a}, active-low
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    if (!blank) seg = glyph(nibble);
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Four-digit common-anode seven-segment scan stage.
// Follows the external digit counter, inserts a blanking gap on every digit
// change, double-buffers the displayed value so updates land on frame
// boundaries (change to digit 0) and optionally suppresses leading zeros.
// Ports:
//   clk, rst  : clock, synchronous active-low reset
//   enable    : 0 forces the display dark
//   digit_sel : active digit index from the counter
//   bus       : value/load in, pending out
//   an        : anode enables, active-low
//   seg       : {g,f,e,d,c,b,a}, active-low
//   state_dbg : current FSM state
// All pins are registered from the previous cycle's state/cur_sel/active.
module seven_seg_scan
  import seg7_pkg::*;
#(
  parameter int BLANK_CYC = 4,
  parameter int LZ_BLANK  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [1:0]             digit_sel,
  seven_seg_scan_if.slave        bus,
  output logic [3:0]             an,
  output logic [6:0]             seg,
  output state_t                 state_dbg
);

  localparam int CW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLANK_CYC - 1);

  state_t      state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]  cur_sel, cur_sel_n;
  logic [15:0] shadow, shadow_n;
  logic [15:0] active, active_n;
  logic        pending, pending_n;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;

  logic        change;
  logic        commit;
  logic [3:0]  nib;
  logic        lz_blank;
  logic [6:0]  dec_seg;

  assign bus.pending = pending;
  assign state_dbg   = state;

  // cur_sel follows digit_sel in every state, so frame-boundary commits
  // keep happening while the display is dark.
  assign change = (digit_sel != cur_sel);
  assign commit = change && (digit_sel == 2'd0) && pending;

  assign nib = active[{cur_sel, 2'b00} +: 4];

  // A digit is a leading zero when it and every more significant nibble
  // are zero; digit 0 is always shown.
  always_comb begin
    lz_blank = 1'b0;
    if (LZ_BLANK != 0) begin
      case (cur_sel)
        2'd3: lz_blank = (active[15:12] == 4'd0);
        2'd2: lz_blank = (active[15:8] == 8'd0);
        2'd1: lz_blank = (active[15:4] == 12'd0);
        default: lz_blank = 1'b0;
      endcase
    end
  end

  seg7_decode u_dec (
    .nibble (nib),
    .blank  (lz_blank),
    .seg    (dec_seg)
  );

  // Next-state, buffer and output logic.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    cur_sel_n = change ? digit_sel : cur_sel;
    shadow_n  = shadow;
    active_n  = active;
    pending_n = pending;
    an_n      = 4'hF;
    seg_n     = SEG_OFF;

    // Commit uses the old shadow; a same-cycle load refills it and keeps
    // pending set.
    if (commit) begin
      active_n  = shadow;
      pending_n = 1'b0;
    end
    if (bus.load) begin
      shadow_n  = bus.value;
      pending_n = 1'b1;
    end

    if (!enable) begin
      state_n = ST_OFF;
      cnt_n   = '0;
    end else begin
      case (state)
        ST_OFF: begin
          state_n = ST_BLANK;
          cnt_n   = '0;
        end
        ST_BLANK: begin
          if (change) begin
            cnt_n = '0;
          end else if (cnt == CNT_LAST) begin
            state_n = ST_SHOW;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        ST_SHOW: begin
          if (change) begin
            state_n = ST_BLANK;
            cnt_n   = '0;
          end
        end
        default: begin
          state_n = ST_BLANK;
          cnt_n   = '0;
        end
      endcase
    end

    if (state == ST_SHOW) begin
      an_n  = ~(4'b0001 << cur_sel);
      seg_n = dec_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_BLANK;
      cnt     <= '0;
      cur_sel <= 2'd0;
      shadow  <= 16'd0;
      active  <= 16'd0;
      pending <= 1'b0;
      an      <= 4'hF;
      seg     <= SEG_OFF;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      cur_sel <= cur_sel_n;
      shadow  <= shadow_n;
      active  <= active_n;
      pending <= pending_n;
      an      <= an_n;
      seg     <= seg_n;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan: hand sequences for reset/gap/commit corner
// cases plus a vector table of committed values and per-digit glyphs.
module tb_seven_seg_scan;
  import seg7_pkg::*;

  localparam int BLANK_CYC = 4;
  // Cycles from changing digit_sel until the new digit is on the pins.
  localparam int SETTLE = BLANK_CYC + 2;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [1:0] digit_sel;
  logic [3:0] an;
  logic [6:0] seg;
  state_t     state_dbg;

  seven_seg_scan_if bus ();

  seven_seg_scan #(.BLANK_CYC(BLANK_CYC), .LZ_BLANK(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .digit_sel (digit_sel),
    .bus       (bus.slave),
    .an        (an),
    .seg       (seg),
    .state_dbg (state_dbg)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [1:0] cur_d = 2'd0;

  typedef struct {
    logic [15:0] value;
    logic [1:0]  d;
    logic [3:0]  an;
    logic [6:0]  seg;
  } vec_t;
  vec_t vecs [24];

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    bus.value = v;
    bus.load  = 1'b1;
    tick();
    bus.load  = 1'b0;
  endtask

  task automatic goto(input logic [1:0] d);
    digit_sel = d;
    repeat (SETTLE) tick();
    cur_d = d;
  endtask

  // Load, then scan forward until the change to digit 0 commits it.
  task automatic commit_value(input logic [15:0] v);
    logic [1:0] nd;
    do_load(v);
    do begin
      nd = cur_d + 2'd1;
      goto(nd);
    end while (cur_d != 2'd0);
  endtask

  initial begin
    int n;
    logic [15:0] last_v;

    vecs[0]  = '{16'h0005, 2'd0, 4'b1110, 7'h12};
    vecs[1]  = '{16'h0005, 2'd1, 4'b1101, 7'h7F};
    vecs[2]  = '{16'h0005, 2'd2, 4'b1011, 7'h7F};
    vecs[3]  = '{16'h0005, 2'd3, 4'b0111, 7'h7F};
    vecs[4]  = '{16'h1234, 2'd0, 4'b1110, 7'h19};
    vecs[5]  = '{16'h1234, 2'd1, 4'b1101, 7'h30};
    vecs[6]  = '{16'h1234, 2'd2, 4'b1011, 7'h24};
    vecs[7]  = '{16'h1234, 2'd3, 4'b0111, 7'h79};
    vecs[8]  = '{16'h0100, 2'd0, 4'b1110, 7'h40};
    vecs[9]  = '{16'h0100, 2'd1, 4'b1101, 7'h40};
    vecs[10] = '{16'h0100, 2'd2, 4'b1011, 7'h79};
    vecs[11] = '{16'h0100, 2'd3, 4'b0111, 7'h7F};
    vecs[12] = '{16'h9F86, 2'd0, 4'b1110, 7'h02};
    vecs[13] = '{16'h9F86, 2'd1, 4'b1101, 7'h00};
    vecs[14] = '{16'h9F86, 2'd2, 4'b1011, 7'h3F};
    vecs[15] = '{16'h9F86, 2'd3, 4'b0111, 7'h10};
    vecs[16] = '{16'h0000, 2'd0, 4'b1110, 7'h40};
    vecs[17] = '{16'h0000, 2'd1, 4'b1101, 7'h7F};
    vecs[18] = '{16'h0000, 2'd2, 4'b1011, 7'h7F};
    vecs[19] = '{16'h0000, 2'd3, 4'b0111, 7'h7F};
    vecs[20] = '{16'h00A7, 2'd0, 4'b1110, 7'h78};
    vecs[21] = '{16'h00A7, 2'd1, 4'b1101, 7'h3F};
    vecs[22] = '{16'h00A7, 2'd2, 4'b1011, 7'h7F};
    vecs[23] = '{16'h00A7, 2'd3, 4'b0111, 7'h7F};

    rst = 1'b0;
    enable = 1'b1;
    digit_sel = 2'd0;
    bus.value = 16'd0;
    bus.load = 1'b0;

    // 1. Reset, then blank gap and first digit
    tick();
    tick();
    check("rst_an", {12'd0, an}, 16'h000F);
    check("rst_seg", {9'd0, seg}, 16'h007F);
    check("rst_pending", {15'd0, bus.pending}, 16'h0000);
    check("rst_state", {14'd0, state_dbg}, {14'd0, ST_BLANK});
    rst = 1'b1;
    n = 0;
    tick();
    while (an == 4'hF && n < 40) begin
      n++;
      tick();
    end
    check("boot_dark_cycles", 16'(n), 16'(BLANK_CYC));
    check("boot_an", {12'd0, an}, 16'h000E);
    check("boot_seg", {9'd0, seg}, 16'h0040);

    // 2. Load 1234, scan; nothing changes until the frame boundary
    do_load(16'h1234);
    check("t2_pending_set", {15'd0, bus.pending}, 16'h0001);
    goto(2'd1);
    check("t2_d1_an", {12'd0, an}, 16'h000D);
    check("t2_d1_seg", {9'd0, seg}, 16'h007F);
    goto(2'd2);
    check("t2_d2_seg", {9'd0, seg}, 16'h007F);
    goto(2'd3);
    check("t2_d3_seg", {9'd0, seg}, 16'h007F);
    check("t2_pending_hold", {15'd0, bus.pending}, 16'h0001);
    goto(2'd0);
    check("t2_d0_an", {12'd0, an}, 16'h000E);
    check("t2_d0_seg", {9'd0, seg}, 16'h0019);
    check("t2_pending_clr", {15'd0, bus.pending}, 16'h0000);

    // 3. Table of committed values and per-digit glyphs
    last_v = 16'h1234;
    for (int i = 0; i < 24; i++) begin
      if (vecs[i].value != last_v) begin
        commit_value(vecs[i].value);
        last_v = vecs[i].value;
      end
      goto(vecs[i].d);
      check($sformatf("vec%0d_an", i), {12'd0, an}, {12'd0, vecs[i].an});
      check($sformatf("vec%0d_seg", i), {9'd0, seg}, {9'd0, vecs[i].seg});
    end

    // 4. Second change two cycles into the gap restarts it (from digit 3)
    digit_sel = 2'd0;
    tick();
    n = 0;
    tick();
    if (an == 4'hF) n++;
    digit_sel = 2'd1;
    tick();
    while (an == 4'hF && n < 40) begin
      n++;
      tick();
    end
    cur_d = 2'd1;
    check("restart_dark_cycles", 16'(n), 16'(2 + BLANK_CYC));
    check("restart_an", {12'd0, an}, 16'h000D);
    check("restart_seg", {9'd0, seg}, 16'h003F);

    // 5. Load in the same cycle as a commit
    do_load(16'h0042);
    goto(2'd2);
    goto(2'd3);
    digit_sel = 2'd0;
    bus.value = 16'hA000;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    check("t5_pending_kept", {15'd0, bus.pending}, 16'h0001);
    repeat (SETTLE - 1) tick();
    cur_d = 2'd0;
    check("t5_d0_seg", {9'd0, seg}, 16'h0024);
    goto(2'd1);
    check("t5_d1_seg", {9'd0, seg}, 16'h0019);
    goto(2'd3);
    check("t5_d3_seg", {9'd0, seg}, 16'h007F);
    goto(2'd0);
    check("t5_next_d0_seg", {9'd0, seg}, 16'h0040);
    check("t5_pending_clr", {15'd0, bus.pending}, 16'h0000);
    goto(2'd3);
    check("t5_dash_an", {12'd0, an}, 16'h0007);
    check("t5_dash_seg", {9'd0, seg}, 16'h003F);

    // 6. Dark display still loads and commits; reset mid-SHOW clears buffers
    enable = 1'b0;
    tick();
    tick();
    check("off_an", {12'd0, an}, 16'h000F);
    check("off_seg", {9'd0, seg}, 16'h007F);
    check("off_state", {14'd0, state_dbg}, {14'd0, ST_OFF});
    do_load(16'h0008);
    check("off_pending_set", {15'd0, bus.pending}, 16'h0001);
    digit_sel = 2'd0;
    cur_d = 2'd0;
    tick();
    check("off_commit", {15'd0, bus.pending}, 16'h0000);
    check("off_still_dark", {12'd0, an}, 16'h000F);
    enable = 1'b1;
    repeat (SETTLE) tick();
    check("on_an", {12'd0, an}, 16'h000E);
    check("on_seg", {9'd0, seg}, 16'h0000);
    do_load(16'h0003);
    rst = 1'b0;
    tick();
    check("midrst_an", {12'd0, an}, 16'h000F);
    check("midrst_seg", {9'd0, seg}, 16'h007F);
    check("midrst_pending", {15'd0, bus.pending}, 16'h0000);
    rst = 1'b1;
    repeat (SETTLE) tick();
    check("post_rst_an", {12'd0, an}, 16'h000E);
    check("post_rst_seg", {9'd0, seg}, 16'h0040);
    check("post_rst_pending", {15'd0, bus.pending}, 16'h0000);
    goto(2'd1);
    goto(2'd0);
    check("post_rst_no_commit", {9'd0, seg}, 16'h0040);

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
